// File: rtl/greenrio_mem_pkg.sv
// Shared types and constants for the greenrio SRAM port arbiter.
package greenrio_mem_pkg;
  localparam int SRAM_DW  = 32;
  localparam int SRAM_BEW = 4;

  // Owner of the SRAM data phase; steers read data to exactly one requester.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_HOST,
    RSP_HOST_MISS,
    RSP_CORE
  } rsp_owner_e;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundles the Wishbone slave, core data port and SRAM macro pins of the arbiter.
interface sram_port_arbiter_if #(
  parameter int AW = 9
);
  import greenrio_mem_pkg::*;

  logic                wbs_cyc_i;
  logic                wbs_stb_i;
  logic                wbs_we_i;
  logic [SRAM_BEW-1:0] wbs_sel_i;
  logic [31:0]         wbs_adr_i;
  logic [SRAM_DW-1:0]  wbs_dat_i;
  logic                wbs_ack_o;
  logic [SRAM_DW-1:0]  wbs_dat_o;

  logic                core_req_i;
  logic                core_we_i;
  logic [SRAM_BEW-1:0] core_be_i;
  logic [AW-1:0]       core_addr_i;
  logic [SRAM_DW-1:0]  core_wdata_i;
  logic                core_gnt_o;
  logic                core_rvalid_o;
  logic [SRAM_DW-1:0]  core_rdata_o;

  logic                sram_ce_o;
  logic                sram_we_o;
  logic [SRAM_BEW-1:0] sram_be_o;
  logic [AW-1:0]       sram_addr_o;
  logic [SRAM_DW-1:0]  sram_wdata_o;
  logic [SRAM_DW-1:0]  sram_rdata_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output sram_ce_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o,
    input  sram_rdata_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  sram_ce_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; req[0] = host, req[1] = core.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_q;  // 1 when the core won most recently

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the Wishbone host port and the core data port.
module sram_port_arbiter
  import greenrio_mem_pkg::*;
#(
  parameter int          AW      = 9,
  parameter logic [31:0] WB_BASE = 32'h3000_0000,
  parameter logic [31:0] WB_MASK = 32'hFFFF_F800
) (
  input logic                wb_clk_i,
  input logic                wb_rst_i,
  sram_port_arbiter_if.slave bus
);
  logic       host_hit;
  logic       host_req;
  logic       host_miss;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       host_gnt;
  logic       core_gnt;
  logic       ack_q;
  logic       rd_q;
  rsp_owner_e rsp_q;

  // The ack cycle masks the still-asserted strobe so a transfer is issued once.
  assign host_hit  = (bus.wbs_adr_i & WB_MASK) == WB_BASE;
  assign host_req  = bus.wbs_cyc_i & bus.wbs_stb_i & host_hit & ~ack_q;
  assign host_miss = bus.wbs_cyc_i & bus.wbs_stb_i & ~host_hit & ~ack_q;
  assign req       = {bus.core_req_i, host_req};

  rr_arb2 u_arb (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .req (req),
    .gnt (gnt)
  );

  assign host_gnt       = gnt[0];
  assign core_gnt       = gnt[1];
  assign bus.core_gnt_o = core_gnt;

  // Address phase: drive the macro from whichever side won this cycle.
  always_comb begin
    bus.sram_ce_o    = host_gnt | core_gnt;
    bus.sram_we_o    = 1'b0;
    bus.sram_be_o    = '0;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    if (host_gnt) begin
      bus.sram_we_o    = bus.wbs_we_i;
      bus.sram_be_o    = bus.wbs_we_i ? bus.wbs_sel_i : 4'hF;
      bus.sram_addr_o  = bus.wbs_adr_i[AW+1:2];
      bus.sram_wdata_o = bus.wbs_dat_i;
    end else if (core_gnt) begin
      bus.sram_we_o    = bus.core_we_i;
      bus.sram_be_o    = bus.core_we_i ? bus.core_be_i : 4'hF;
      bus.sram_addr_o  = bus.core_addr_i;
      bus.sram_wdata_o = bus.core_wdata_i;
    end
  end

  // Data phase: record who owns the response returned next cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      rd_q  <= 1'b0;
      rsp_q <= RSP_NONE;
    end else begin
      ack_q <= host_gnt | host_miss;
      rd_q  <= (host_gnt & ~bus.wbs_we_i) | (core_gnt & ~bus.core_we_i);
      if (core_gnt)       rsp_q <= RSP_CORE;
      else if (host_gnt)  rsp_q <= RSP_HOST;
      else if (host_miss) rsp_q <= RSP_HOST_MISS;
      else                rsp_q <= RSP_NONE;
    end
  end

  // A miss acks alongside a core response, so ack is kept apart from rsp_q.
  assign bus.wbs_ack_o     = ack_q;
  assign bus.wbs_dat_o     = (rsp_q == RSP_HOST && rd_q) ? bus.sram_rdata_i : '0;
  assign bus.core_rvalid_o = (rsp_q == RSP_CORE);
  assign bus.core_rdata_o  = (rsp_q == RSP_CORE && rd_q) ? bus.sram_rdata_i : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM macro.
module tb_sram_port_arbiter;
  import greenrio_mem_pkg::*;

  localparam int          AW      = 9;
  localparam logic [31:0] WB_BASE = 32'h3000_0000;
  localparam logic [31:0] WB_MASK = 32'hFFFF_F800;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.AW(AW)) bus ();

  sram_port_arbiter #(.AW(AW), .WB_BASE(WB_BASE), .WB_MASK(WB_MASK)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] sram_rd = '0;
  exp_t        host_q[$];
  exp_t        core_q[$];
  byte         log_who[$];
  int          log_cyc[$];
  logic [31:0] rd;
  int          lat;

  assign bus.sram_rdata_i = sram_rd;

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | (i * 32'h0001_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Behavioural SRAM: filled with a known pattern while reset is held.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
    end else if (bus.sram_ce_o) begin
      if (bus.sram_we_o) mem[bus.sram_addr_o] <= merge(mem[bus.sram_addr_o], bus.sram_wdata_o, bus.sram_be_o);
      else               sram_rd <= mem[bus.sram_addr_o];
    end
  end

  task automatic monitor_step();
    exp_t e;
    logic pend;
    logic hit;
    if (rst) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
      return;
    end
    pend = bus.wbs_cyc_i & bus.wbs_stb_i & ~bus.wbs_ack_o;
    hit  = (bus.wbs_adr_i & WB_MASK) == WB_BASE;
    if (bus.wbs_ack_o) begin
      if (host_q.size() == 0) chk("host_ack_unexpected", 1, 0);
      else begin
        e = host_q.pop_front();
        chk("host_dat", bus.wbs_dat_o, e.data);
        chk("host_lat", cyc_n, e.cyc + 1);
      end
    end
    if (bus.core_rvalid_o) begin
      if (core_q.size() == 0) chk("core_rvalid_unexpected", 1, 0);
      else begin
        e = core_q.pop_front();
        chk("core_rdata", bus.core_rdata_o, e.data);
        chk("core_lat", cyc_n, e.cyc + 1);
      end
    end
    if (bus.core_gnt_o) begin
      chk("core_ce", bus.sram_ce_o, 1);
      chk("core_addr", bus.sram_addr_o, bus.core_addr_i);
      chk("core_be", bus.sram_be_o, bus.core_we_i ? bus.core_be_i : 4'hF);
      chk("core_we", bus.sram_we_o, bus.core_we_i);
      e.data = bus.core_we_i ? 32'h0 : ref_mem[bus.core_addr_i];
      e.cyc  = cyc_n;
      core_q.push_back(e);
      if (bus.core_we_i) begin
        chk("core_wdata", bus.sram_wdata_o, bus.core_wdata_i);
        ref_mem[bus.core_addr_i] = merge(ref_mem[bus.core_addr_i], bus.core_wdata_i, bus.core_be_i);
      end
      log_who.push_back("C");
      log_cyc.push_back(cyc_n);
    end
    if (pend && hit && !bus.core_gnt_o) begin
      chk("host_ce", bus.sram_ce_o, 1);
      chk("host_addr", bus.sram_addr_o, bus.wbs_adr_i[AW+1:2]);
      chk("host_be", bus.sram_be_o, bus.wbs_we_i ? bus.wbs_sel_i : 4'hF);
      e.data = bus.wbs_we_i ? 32'h0 : ref_mem[bus.wbs_adr_i[AW+1:2]];
      e.cyc  = cyc_n;
      host_q.push_back(e);
      if (bus.wbs_we_i)
        ref_mem[bus.wbs_adr_i[AW+1:2]] = merge(ref_mem[bus.wbs_adr_i[AW+1:2]], bus.wbs_dat_i, bus.wbs_sel_i);
      log_who.push_back("H");
      log_cyc.push_back(cyc_n);
    end
    if (pend && !hit) begin
      chk("miss_ce", bus.sram_ce_o, bus.core_gnt_o);
      e.data = 32'h0;
      e.cyc  = cyc_n;
      host_q.push_back(e);
    end
    if (!bus.core_req_i && !(pend && hit)) chk("idle_ce", bus.sram_ce_o, 0);
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic host_op(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] rdat, output int l);
    int start;
    bit got;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
    start = cyc_n; got = 1'b0; rdat = '0; l = -1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        got = 1'b1; rdat = bus.wbs_dat_o; l = cyc_n - start;
      end
    end
    if (!got) chk("host_timeout", 0, 1);
  endtask

  task automatic host_idle();
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic core_op(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                         input logic [31:0] d);
    bit got;
    @(posedge clk); #1;
    bus.core_req_i = 1'b1; bus.core_we_i = we; bus.core_be_i = be;
    bus.core_addr_i = a; bus.core_wdata_i = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.core_gnt_o) got = 1'b1;
    end
    if (!got) chk("core_timeout", 0, 1);
  endtask

  task automatic core_idle();
    @(posedge clk); #1;
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.core_req_i = 0; bus.core_we_i = 0; bus.core_be_i = 0;
    bus.core_addr_i = 0; bus.core_wdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", bus.wbs_ack_o, 0);
    chk("rst_rvalid", bus.core_rvalid_o, 0);
    chk("rst_ce", bus.sram_ce_o, 0);
    chk("rst_gnt", bus.core_gnt_o, 0);
    chk("rst_wbs_dat", bus.wbs_dat_o, 0);
    chk("rst_core_rdata", bus.core_rdata_o, 0);
    rst = 1'b0;

    // Reset during a core data phase drops the pending response at once.
    core_op(1'b0, 4'hF, 9'd0, 32'h0);
    @(posedge clk); #1;
    bus.core_req_i = 1'b0;
    chk("t1_rvalid_pending", bus.core_rvalid_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("t1_rvalid_rst", bus.core_rvalid_o, 0);
    chk("t1_rdata_rst", bus.core_rdata_o, 0);
    host_q.delete(); core_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    // Both sides request every cycle right after reset: host wins the first tie.
    log_who.delete(); log_cyc.delete();
    fork
      begin
        logic [31:0] r4;
        int l4;
        for (int i = 0; i < 4; i++) host_op(1'b0, 4'hF, WB_BASE + 32'h40 + 32'(4 * i), 32'h0, r4, l4);
        host_idle();
      end
      begin
        for (int i = 0; i < 4; i++) core_op(1'b0, 4'hF, 9'(32 + i), 32'h0);
        core_idle();
      end
    join
    chk("t4_grants", log_who.size(), 8);
    chk("t4_first", log_who[0], "H");
    for (int i = 1; i < log_who.size(); i++) begin
      chk("t4_alternate", log_who[i] != log_who[i-1], 1);
      chk("t4_back_to_back", log_cyc[i], log_cyc[i-1] + 1);
    end

    host_op(1'b1, 4'hF, 32'h3000_0010, 32'hDEADBEEF, rd, lat);
    chk("t2_wr_lat", lat, 1);
    host_idle();
    host_op(1'b0, 4'hF, 32'h3000_0010, 32'h0, rd, lat);
    chk("t2_rd_lat", lat, 1);
    chk("t2_rd_data", rd, 32'hDEADBEEF);
    host_idle();

    core_op(1'b1, 4'b0011, 9'd4, 32'h0000_1234);
    core_idle();
    core_op(1'b0, 4'hF, 9'd4, 32'h0);
    core_idle();
    @(negedge clk);
    chk("t3_rvalid", bus.core_rvalid_o, 1);
    chk("t3_rd_data", bus.core_rdata_o, 32'hDEAD1234);

    log_who.delete(); log_cyc.delete();
    for (int i = 0; i < 4; i++) core_op(1'b0, 4'hF, 9'(i), 32'h0);
    core_idle();
    repeat (2) @(posedge clk);
    chk("t5_grants", log_who.size(), 4);
    for (int i = 1; i < log_cyc.size(); i++) chk("t5_consecutive", log_cyc[i], log_cyc[i-1] + 1);

    host_op(1'b0, 4'hF, 32'h2000_0000, 32'h0, rd, lat);
    chk("t6_miss_lat", lat, 1);
    chk("t6_miss_data", rd, 32'h0);
    host_idle();

    repeat (3) @(posedge clk);
    chk("host_q_drained", host_q.size(), 0);
    chk("core_q_drained", core_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
